keycode_event_sequencer: RTL and testbench

Turns the raw 8-bit keycode from the NIOS keycode PIO into an ordered stream of press, release and auto-repeat events for the game logic. It tracks the currently held key and queues events in a small FIFO. Game logic drains one event per handshake, typically once per frame. It sits between the PIO `out_port` and the player and menu state machines, which otherwise see only a level and miss short taps between frames.

---
 rtl/keyevt_pkg.sv | 24 ++
 rtl/keyevt_fifo.sv | 55 +++++
 rtl/keycode_event_sequencer.sv | 155 +++++++++++++++
 tb/tb_keycode_event_sequencer.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyevt_pkg.sv
// keyevt_pkg: shared types for the keycode event sequencer.
// Event type codes, FIFO entry layout and sequencer FSM states.
package keyevt_pkg;

    localparam int EVT_W = 10;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_type_e;

    typedef struct packed {
        evt_type_e  etype;
        logic [7:0] code;
    } evt_t;

    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_PRESS_PEND = 1'b1
    } seq_state_e;

endpackage

// File: rtl/keyevt_fifo.sv
// keyevt_fifo: first-word-fall-through event FIFO.
// Ports: push/push_data write side, pop read side, head = oldest entry,
// empty flag, drop = push refused because full with no pop.
module keyevt_fifo #(
    parameter int DEPTH = 4,
    parameter int EVT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [EVT_W-1:0] push_data,
    input  logic             pop,
    output logic [EVT_W-1:0] head,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/keycode_event_sequencer.sv
// keycode_event_sequencer: turns the PIO keycode level into PRESS,
// RELEASE and REPEAT events queued for the game logic.
// Ports: clk, reset (sync, active-high), keycode_in, frame_tick,
// evt_ready/evt_valid/evt_type/evt_code (event stream), held_code,
// overflow (sticky drop flag) and clr_overflow.
module keycode_event_sequencer #(
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keycode_in,
    input  logic       frame_tick,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_type,
    output logic [7:0] evt_code,
    output logic [7:0] held_code,
    output logic       overflow,
    input  logic       clr_overflow
);

    import keyevt_pkg::*;

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                          REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(RMAX + 1);

    seq_state_e    state;
    logic [7:0]    kc_q;
    logic [7:0]    pend_code;
    logic [CW-1:0] rpt_cnt;
    logic          rpt_first;
    logic          rpt_due;
    logic [CW:0]   rpt_inc;
    logic [CW:0]   rpt_lim;
    logic          key_chg;
    logic          push;
    logic          pop;
    logic          empty;
    logic          drop;
    evt_t          push_evt;
    evt_t          head;

    assign key_chg = (state == ST_IDLE) && (kc_q != held_code);
    assign rpt_inc = {1'b0, rpt_cnt} + (CW+1)'(1);
    assign rpt_lim = rpt_first ? (CW+1)'(REPEAT_DELAY)
                               : (CW+1)'(REPEAT_RATE);

    always_ff @(posedge clk) begin
        if (reset) begin
            kc_q <= 8'h00;
        end else begin
            kc_q <= keycode_in;
        end
    end

    // A change outranks a due repeat, which is then simply lost.
    always_comb begin
        push           = 1'b0;
        push_evt.etype = EVT_NONE;
        push_evt.code  = 8'h00;
        if (state == ST_PRESS_PEND) begin
            push           = 1'b1;
            push_evt.etype = EVT_PRESS;
            push_evt.code  = pend_code;
        end else if (key_chg) begin
            push = 1'b1;
            if (held_code != 8'h00) begin
                push_evt.etype = EVT_RELEASE;
                push_evt.code  = held_code;
            end else begin
                push_evt.etype = EVT_PRESS;
                push_evt.code  = kc_q;
            end
        end else if (rpt_due) begin
            push           = 1'b1;
            push_evt.etype = EVT_REPEAT;
            push_evt.code  = held_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            held_code <= 8'h00;
            pend_code <= 8'h00;
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
            rpt_due   <= 1'b0;
        end else begin
            rpt_due <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_chg) begin
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b1;
                        if (held_code != 8'h00 && kc_q != 8'h00) begin
                            pend_code <= kc_q;
                            state     <= ST_PRESS_PEND;
                        end else begin
                            held_code <= kc_q;
                        end
                    end else if (held_code != 8'h00 && frame_tick) begin
                        // Reload on expiry so the count never wraps.
                        if (rpt_inc >= rpt_lim) begin
                            rpt_cnt   <= '0;
                            rpt_first <= 1'b0;
                            rpt_due   <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_inc[CW-1:0];
                        end
                    end
                end
                ST_PRESS_PEND: begin
                    held_code <= pend_code;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign pop = !empty && evt_ready;

    keyevt_fifo #(
        .DEPTH (DEPTH),
        .EVT_W (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .drop      (drop)
    );

    assign evt_valid = !empty;
    assign evt_type  = head.etype;
    assign evt_code  = head.code;

endmodule

// File: tb/tb_keycode_event_sequencer.sv
// tb_keycode_event_sequencer: directed scenarios plus randomized
// stimulus checked against an event-level reference model.
module tb_keycode_event_sequencer;

    localparam int DEPTH = 4;
    localparam int DELAY = 30;
    localparam int RATE  = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] keycode_in = 8'h00;
    logic       frame_tick = 1'b0;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [7:0] evt_code;
    logic [7:0] held_code;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [9:0] m_q[$];
    logic [7:0] m_seen = 8'h00;
    logic [7:0] m_held = 8'h00;
    logic [7:0] m_pcode = 8'h00;
    bit         m_pend = 1'b0;
    bit         m_rnext = 1'b0;
    bit         m_ovf = 1'b0;
    int         m_ticks = 0;

    logic [9:0] got[$];
    int         at[$];

    keycode_event_sequencer #(
        .DEPTH        (DEPTH),
        .REPEAT_DELAY (DELAY),
        .REPEAT_RATE  (RATE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .keycode_in   (keycode_in),
        .frame_tick   (frame_tick),
        .evt_ready    (evt_ready),
        .evt_valid    (evt_valid),
        .evt_type     (evt_type),
        .evt_code     (evt_code),
        .held_code    (held_code),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advances the model by one clock using the inputs now applied.
    task automatic model_step();
        logic [9:0] ev;
        bit         has;
        bit         drop;
        has  = 1'b0;
        drop = 1'b0;
        ev   = '0;
        if (reset) begin
            m_q.delete();
            m_seen  = 8'h00;
            m_held  = 8'h00;
            m_pcode = 8'h00;
            m_pend  = 1'b0;
            m_rnext = 1'b0;
            m_ovf   = 1'b0;
            m_ticks = 0;
            return;
        end
        if (m_pend) begin
            has     = 1'b1;
            ev      = {2'd1, m_pcode};
            m_held  = m_pcode;
            m_pend  = 1'b0;
            m_rnext = 1'b0;
        end else if (m_seen != m_held) begin
            has = 1'b1;
            if (m_held != 8'h00) begin
                ev = {2'd2, m_held};
                if (m_seen != 8'h00) begin
                    m_pend  = 1'b1;
                    m_pcode = m_seen;
                end else begin
                    m_held = 8'h00;
                end
            end else begin
                ev     = {2'd1, m_seen};
                m_held = m_seen;
            end
            m_ticks = 0;
            m_rnext = 1'b0;
        end else begin
            if (m_rnext) begin
                has = 1'b1;
                ev  = {2'd3, m_held};
            end
            m_rnext = 1'b0;
            if (m_held != 8'h00 && frame_tick) begin
                m_ticks++;
                if (m_ticks >= DELAY && (m_ticks - DELAY) % RATE == 0)
                    m_rnext = 1'b1;
            end
        end
        if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
        if (has) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr_overflow) m_ovf = 1'b0;
        m_seen = keycode_in;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", evt_valid);
        end
        n_cmp++;
        if ({evt_type, evt_code} !== 10'h000) begin
            n_bad++;
            $display("FAIL reset_head: got %h want 000", {evt_type, evt_code});
        end
        n_cmp++;
        if (held_code !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_held: got %h want 00", held_code);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ovf: got %b want 0", overflow);
        end
    endtask

    task automatic test_tap();
        evt_ready  = 1'b0;
        keycode_in = 8'h1A;
        cyc();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL tap_lat1: got %b want 0", evt_valid);
        end
        cyc();
        n_cmp++;
        if ({evt_valid, evt_type, evt_code} !== {1'b1, 2'd1, 8'h1A}) begin
            n_bad++;
            $display("FAIL tap_press: got %h want %h",
                     {evt_valid, evt_type, evt_code}, {1'b1, 2'd1, 8'h1A});
        end
        cyc();
        keycode_in = 8'h00;
        run(4);
        n_cmp++;
        if (held_code !== 8'h00) begin
            n_bad++;
            $display("FAIL tap_held: got %h want 00", held_code);
        end
        evt_ready = 1'b1;
        cyc();
        n_cmp++;
        if ({evt_valid, evt_type, evt_code} !== {1'b1, 2'd2, 8'h1A}) begin
            n_bad++;
            $display("FAIL tap_release: got %h want %h",
                     {evt_valid, evt_type, evt_code}, {1'b1, 2'd2, 8'h1A});
        end
        cyc();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL tap_empty: got %b want 0", evt_valid);
        end
    endtask

    task automatic test_swap();
        evt_ready  = 1'b1;
        keycode_in = 8'h04;
        run(2);
        n_cmp++;
        if ({evt_valid, evt_type, evt_code} !== {1'b1, 2'd1, 8'h04}) begin
            n_bad++;
            $display("FAIL swap_press04: got %h want %h",
                     {evt_valid, evt_type, evt_code}, {1'b1, 2'd1, 8'h04});
        end
        cyc();
        keycode_in = 8'h07;
        run(2);
        n_cmp++;
        if ({evt_valid, evt_type, evt_code, held_code} !==
            {1'b1, 2'd2, 8'h04, 8'h04}) begin
            n_bad++;
            $display("FAIL swap_release04: got %h want %h",
                     {evt_valid, evt_type, evt_code, held_code},
                     {1'b1, 2'd2, 8'h04, 8'h04});
        end
        cyc();
        n_cmp++;
        if ({evt_valid, evt_type, evt_code, held_code} !==
            {1'b1, 2'd1, 8'h07, 8'h07}) begin
            n_bad++;
            $display("FAIL swap_press07: got %h want %h",
                     {evt_valid, evt_type, evt_code, held_code},
                     {1'b1, 2'd1, 8'h07, 8'h07});
        end
        cyc();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL swap_empty: got %b want 0", evt_valid);
        end
    endtask

    task automatic test_reset_mid();
        evt_ready  = 1'b1;
        keycode_in = 8'h04;
        run(5);
        keycode_in = 8'h07;
        run(2);
        n_cmp++;
        if ({evt_valid, evt_type, evt_code, held_code} !==
            {1'b1, 2'd2, 8'h04, 8'h04}) begin
            n_bad++;
            $display("FAIL rmid_pend: got %h want %h",
                     {evt_valid, evt_type, evt_code, held_code},
                     {1'b1, 2'd2, 8'h04, 8'h04});
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp++;
        if ({evt_valid, held_code, overflow} !== {1'b0, 8'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL rmid_after: got %h want 000",
                     {evt_valid, held_code, overflow});
        end
        cyc();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_lat1: got %b want 0", evt_valid);
        end
        cyc();
        n_cmp++;
        if ({evt_valid, evt_type, evt_code} !== {1'b1, 2'd1, 8'h07}) begin
            n_bad++;
            $display("FAIL rmid_press07: got %h want %h",
                     {evt_valid, evt_type, evt_code}, {1'b1, 2'd1, 8'h07});
        end
        keycode_in = 8'h00;
        run(5);
    endtask

    task automatic test_repeat();
        logic [9:0] exp_ev[5];
        int         exp_at[5];
        exp_ev = '{{2'd1, 8'h2C}, {2'd3, 8'h2C}, {2'd3, 8'h2C},
                   {2'd3, 8'h2C}, {2'd2, 8'h2C}};
        exp_at = '{0, 30, 36, 42, 100};
        evt_ready = 1'b1;
        got.delete();
        at.delete();
        keycode_in = 8'h2C;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (evt_valid) begin
                got.push_back({evt_type, evt_code});
                at.push_back(0);
            end
        end
        for (int t = 1; t <= 50; t++) begin
            if (t == 43) keycode_in = 8'h00;
            for (int k = 0; k < 4; k++) begin
                frame_tick = (k == 0);
                cyc();
                frame_tick = 1'b0;
                if (evt_valid) begin
                    got.push_back({evt_type, evt_code});
                    at.push_back(t > 42 ? 100 : t);
                end
            end
        end
        n_cmp++;
        if (got.size() !== 5) begin
            n_bad++;
            $display("FAIL rpt_count: got %0d events want 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_ev[i] || at[i] !== exp_at[i]) begin
                n_bad++;
                $display("FAIL rpt_event%0d: got %h@%0d want %h@%0d",
                         i, got[i], at[i], exp_ev[i], exp_at[i]);
            end
        end
    endtask

    task automatic test_collision();
        evt_ready  = 1'b1;
        keycode_in = 8'h2C;
        run(5);
        for (int t = 1; t < DELAY; t++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            run(3);
        end
        got.delete();
        frame_tick = 1'b1;
        keycode_in = 8'h3B;
        cyc();
        frame_tick = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (evt_valid) got.push_back({evt_type, evt_code});
        end
        n_cmp++;
        if (got.size() !== 2) begin
            n_bad++;
            $display("FAIL coll_count: got %0d events want 2", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== {2'd2, 8'h2C} || got[1] !== {2'd1, 8'h3B}) begin
                n_bad++;
                $display("FAIL coll_order: got %h %h want 22c 13b",
                         got[0], got[1]);
            end
        end
        n_cmp++;
        if (held_code !== 8'h3B) begin
            n_bad++;
            $display("FAIL coll_held: got %h want 3b", held_code);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] exp_ev[4];
        logic [7:0] codes[3];
        exp_ev = '{{2'd2, 8'h11}, {2'd1, 8'h12}, {2'd2, 8'h12},
                   {2'd1, 8'h33}};
        codes  = '{8'h11, 8'h12, 8'h13};
        evt_ready  = 1'b1;
        keycode_in = 8'h00;
        run(5);
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            keycode_in = codes[i];
            run(3);
            keycode_in = 8'h00;
            run(3);
        end
        n_cmp++;
        if ({overflow, held_code, evt_valid, evt_type, evt_code} !==
            {1'b1, 8'h00, 1'b1, 2'd1, 8'h11}) begin
            n_bad++;
            $display("FAIL ovf_set: got %h want %h",
                     {overflow, held_code, evt_valid, evt_type, evt_code},
                     {1'b1, 8'h00, 1'b1, 2'd1, 8'h11});
        end
        clr_overflow = 1'b1;
        cyc();
        clr_overflow = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        keycode_in = 8'h33;
        cyc();
        evt_ready = 1'b1;
        cyc();
        evt_ready = 1'b0;
        n_cmp++;
        if ({overflow, held_code, evt_type, evt_code} !==
            {1'b0, 8'h33, 2'd2, 8'h11}) begin
            n_bad++;
            $display("FAIL ovf_pushpop: got %h want %h",
                     {overflow, held_code, evt_type, evt_code},
                     {1'b0, 8'h33, 2'd2, 8'h11});
        end
        clr_overflow = 1'b1;
        keycode_in   = 8'h00;
        cyc();
        cyc();
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_clr_vs_drop: got %b want 1", overflow);
        end
        cyc();
        clr_overflow = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clr_after: got %b want 0", overflow);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({evt_valid, evt_type, evt_code} !== {1'b1, exp_ev[i]}) begin
                n_bad++;
                $display("FAIL ovf_drain%0d: got %h want %h", i,
                         {evt_valid, evt_type, evt_code}, {1'b1, exp_ev[i]});
            end
            cyc();
        end
        n_cmp++;
        if ({evt_valid, held_code} !== {1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL ovf_end: got %h want 000", {evt_valid, held_code});
        end
    endtask

    task automatic test_random();
        logic [7:0] keys[5];
        int         hold;
        keys = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h2C};
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                keycode_in = keys[$urandom_range(0, 4)];
                hold = ($urandom_range(0, 3) == 0) ?
                       $urandom_range(60, 200) : $urandom_range(1, 8);
            end
            hold--;
            frame_tick   = ($urandom_range(0, 2) == 0);
            evt_ready    = ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 19) == 0);
            reset        = ($urandom_range(0, 599) == 0);
            cyc();
            n_cmp++;
            if (evt_valid !== (m_q.size() > 0)) begin
                n_bad++;
                $display("FAIL rnd_valid c%0d: got %b want %b",
                         c, evt_valid, m_q.size() > 0);
            end else if (m_q.size() > 0) begin
                n_cmp++;
                if ({evt_type, evt_code} !== m_q[0]) begin
                    n_bad++;
                    $display("FAIL rnd_head c%0d: got %h want %h",
                             c, {evt_type, evt_code}, m_q[0]);
                end
            end
            n_cmp++;
            if ({held_code, overflow} !== {m_held, m_ovf}) begin
                n_bad++;
                $display("FAIL rnd_state c%0d: got %h want %h",
                         c, {held_code, overflow}, {m_held, m_ovf});
            end
        end
        reset        = 1'b0;
        frame_tick   = 1'b0;
        clr_overflow = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tap();
        test_swap();
        test_reset_mid();
        test_repeat();
        test_collision();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
